// File: rtl/jtframe_6801per.sv
// On-chip peripherals for the 6801/63701 wrapper: I/O ports with DDRs, the
// free-running timer with output compare, input capture and overflow, and scratch RAM.
module jtframe_6801per #(
    parameter int unsigned PORTS  = 4,
    parameter int unsigned PRESC  = 1,
    parameter int unsigned MAXREG = 27
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        cs,
    input  logic        wrn,
    input  logic [4:0]  addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic [31:0] p_in,
    output logic [31:0] p_out,
    output logic [31:0] p_ddr,
    input  logic        icap_in,
    output logic        ocmp_out,
    output logic        irq_icf,
    output logic        irq_ocf,
    output logic        irq_tof
);

    localparam int unsigned NPORT = 4;
    localparam int unsigned NREG  = 32;
    localparam int unsigned SCR0  = 15;
    localparam logic [7:0]  PTOP  = 8'(PRESC - 1);

    localparam logic [4:0] A_TCSR = 5'h08;
    localparam logic [4:0] A_FRCH = 5'h09;
    localparam logic [4:0] A_FRCL = 5'h0A;
    localparam logic [4:0] A_OCRH = 5'h0B;
    localparam logic [4:0] A_OCRL = 5'h0C;
    localparam logic [4:0] A_ICRH = 5'h0D;
    localparam logic [4:0] A_ICRL = 5'h0E;

    logic [7:0]  ddr  [NPORT];
    logic [7:0]  pdat [NPORT];
    logic [7:0]  scr  [NREG];
    logic [4:0]  ctrl;
    logic        icf, ocf, tof;
    logic        arm_icf, arm_ocf, arm_tof;
    logic [15:0] frc, ocr, icr, frc_inc;
    logic [7:0]  latch, pcnt, pin_b;
    logic        icap_q;

    logic        wr_ev, rd_ev, port_sel, port_ok, scr_sel;
    logic [1:0]  pidx;
    logic        frc_wr, ocr_wr, tcsr_rd, tick, cap;
    logic        set_tof, set_ocf, clr_tof, clr_ocf, clr_icf;

    // Port n lives at {addr[2],addr[0]}; addr[1] selects data over DDR
    assign pidx     = {addr[2], addr[0]};
    assign port_sel = addr[4:3] == 2'b00;
    assign port_ok  = 32'(pidx) < PORTS;
    assign scr_sel  = (32'(addr) >= SCR0) && (32'(addr) <= MAXREG);
    assign pin_b    = p_in[{pidx, 3'b000} +: 8];

    assign wr_ev   = cs && cen && !wrn;
    assign rd_ev   = cs && cen && wrn;
    assign frc_wr  = wr_ev && addr == A_FRCH;
    assign ocr_wr  = wr_ev && (addr == A_OCRH || addr == A_OCRL);
    assign tcsr_rd = rd_ev && addr == A_TCSR;

    // A counter load restarts the prescaler, so that cycle never ticks
    assign tick    = cen && !frc_wr && pcnt == PTOP;
    assign frc_inc = frc + 16'd1;
    assign cap     = cen && (ctrl[1] ? (!icap_q && icap_in) : (icap_q && !icap_in));

    assign set_tof = tick && frc == 16'hFFFF;
    assign set_ocf = tick && !ocr_wr && frc_inc == ocr;
    assign clr_tof = rd_ev && addr == A_FRCH && arm_tof;
    assign clr_ocf = ocr_wr && arm_ocf;
    assign clr_icf = rd_ev && addr == A_ICRH && arm_icf;

    assign irq_icf = icf && ctrl[4];
    assign irq_ocf = ocf && ctrl[3];
    assign irq_tof = tof && ctrl[2];

    for (genvar g = 0; g < NPORT; g++) begin : g_port
        assign p_out[8*g +: 8] = pdat[g];
        assign p_ddr[8*g +: 8] = ddr[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPORT; i++) begin
                ddr[i]  <= '0;
                pdat[i] <= '0;
            end
        end else if (wr_ev && port_sel && port_ok) begin
            if (addr[1]) pdat[pidx] <= din;
            else         ddr[pidx]  <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) scr[i] <= '0;
        end else if (wr_ev && scr_sel) begin
            scr[addr] <= din;
        end
    end

    // Timer, compare/capture and the read-then-access flag clear protocol
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl     <= '0;
            frc      <= '0;
            ocr      <= 16'hFFFF;
            icr      <= '0;
            latch    <= '0;
            pcnt     <= '0;
            ocmp_out <= 1'b0;
            icf      <= 1'b0;
            ocf      <= 1'b0;
            tof      <= 1'b0;
            arm_icf  <= 1'b0;
            arm_ocf  <= 1'b0;
            arm_tof  <= 1'b0;
            icap_q   <= icap_in;
        end else begin
            if (cen) begin
                icap_q <= icap_in;
                if (frc_wr || pcnt == PTOP) pcnt <= '0;
                else                        pcnt <= pcnt + 8'd1;
            end
            if (frc_wr)    frc <= 16'hFFF8;
            else if (tick) frc <= frc_inc;
            if (wr_ev && addr == A_TCSR) ctrl       <= din[4:0];
            if (wr_ev && addr == A_OCRH) ocr[15:8]  <= din;
            if (wr_ev && addr == A_OCRL) ocr[7:0]   <= din;
            if (rd_ev && addr == A_FRCH) latch      <= frc[7:0];
            if (cap)     icr      <= frc;
            if (set_ocf) ocmp_out <= ctrl[0];

            if (set_tof)      tof <= 1'b1;
            else if (clr_tof) tof <= 1'b0;
            if (set_ocf)      ocf <= 1'b1;
            else if (clr_ocf) ocf <= 1'b0;
            if (cap)          icf <= 1'b1;
            else if (clr_icf) icf <= 1'b0;

            if (clr_tof)             arm_tof <= 1'b0;
            else if (tcsr_rd && tof) arm_tof <= 1'b1;
            if (clr_ocf)             arm_ocf <= 1'b0;
            else if (tcsr_rd && ocf) arm_ocf <= 1'b1;
            if (clr_icf)             arm_icf <= 1'b0;
            else if (tcsr_rd && icf) arm_icf <= 1'b1;
        end
    end

    always_comb begin
        dout = 8'hFF;
        if (port_sel) begin
            if (port_ok)
                dout = addr[1] ? ((pdat[pidx] & ddr[pidx]) | (pin_b & ~ddr[pidx]))
                               : ddr[pidx];
        end else begin
            case (addr)
                A_TCSR:  dout = {icf, ocf, tof, ctrl};
                A_FRCH:  dout = frc[15:8];
                A_FRCL:  dout = latch;
                A_OCRH:  dout = ocr[15:8];
                A_OCRL:  dout = ocr[7:0];
                A_ICRH:  dout = icr[15:8];
                A_ICRL:  dout = icr[7:0];
                default: if (scr_sel) dout = scr[addr];
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_6801per.sv
// Directed bench for jtframe_6801per: a register vector table plus hand-written
// timer sequences on a default instance, a PORTS=2 instance and a PRESC=4 instance.
module tb_jtframe_6801per;

    logic        clk = 1'b0;
    logic        rst, cen, cs, wrn, icap_in;
    logic [4:0]  addr;
    logic [7:0]  din;
    logic [31:0] p_in;

    logic [7:0]  dout, d2_dout, d4_dout;
    logic [31:0] p_out, p_ddr, p2_out, p2_ddr, p4_out, p4_ddr;
    logic        ocmp, icf_i, ocf_i, tof_i;
    logic        ocmp2, icf2, ocf2, tof2;
    logic        ocmp4, icf4, ocf4, tof4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jtframe_6801per u_dut (
        .clk(clk), .rst(rst), .cen(cen), .cs(cs), .wrn(wrn), .addr(addr), .din(din),
        .dout(dout), .p_in(p_in), .p_out(p_out), .p_ddr(p_ddr), .icap_in(icap_in),
        .ocmp_out(ocmp), .irq_icf(icf_i), .irq_ocf(ocf_i), .irq_tof(tof_i)
    );

    jtframe_6801per #(.PORTS(2)) u_p2 (
        .clk(clk), .rst(rst), .cen(cen), .cs(cs), .wrn(wrn), .addr(addr), .din(din),
        .dout(d2_dout), .p_in(p_in), .p_out(p2_out), .p_ddr(p2_ddr), .icap_in(icap_in),
        .ocmp_out(ocmp2), .irq_icf(icf2), .irq_ocf(ocf2), .irq_tof(tof2)
    );

    jtframe_6801per #(.PRESC(4)) u_p4 (
        .clk(clk), .rst(rst), .cen(cen), .cs(cs), .wrn(wrn), .addr(addr), .din(din),
        .dout(d4_dout), .p_in(p_in), .p_out(p4_out), .p_ddr(p4_ddr), .icap_in(icap_in),
        .ocmp_out(ocmp4), .irq_icf(icf4), .irq_ocf(ocf4), .irq_tof(tof4)
    );

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] din;
        logic [4:0] chk;
        logic [7:0] exp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        cs = 1'b1; wrn = 1'b0; addr = a; din = d; cen = 1'b1;
        step();
        cs = 1'b0; wrn = 1'b1; cen = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string name);
        cs = 1'b1; wrn = 1'b1; addr = a; cen = 1'b1;
        #2;
        check(name, 32'(dout), 32'(exp));
        step();
        cs = 1'b0; cen = 1'b0;
    endtask

    task automatic idle(input int n);
        cs = 1'b0; cen = 1'b1;
        repeat (n) step();
        cen = 1'b0;
    endtask

    // Combinational look at a register with no access event
    task automatic peek(input logic [4:0] a);
        cs = 1'b0; cen = 1'b0; addr = a;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cen = 1'b0; cs = 1'b0; wrn = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time bound expired");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 5'h00, 8'hF0, 5'h00, 8'hF0};
        vecs[1]  = '{1'b1, 5'h02, 8'hA5, 5'h02, 8'hAC};
        vecs[2]  = '{1'b1, 5'h01, 8'hFF, 5'h03, 8'h00};
        vecs[3]  = '{1'b1, 5'h03, 8'h81, 5'h03, 8'h81};
        vecs[4]  = '{1'b1, 5'h05, 8'h00, 5'h07, 8'hC3};
        vecs[5]  = '{1'b1, 5'h07, 8'h3C, 5'h07, 8'hC3};
        vecs[6]  = '{1'b1, 5'h04, 8'h0F, 5'h06, 8'h90};
        vecs[7]  = '{1'b1, 5'h06, 8'h77, 5'h06, 8'h97};
        vecs[8]  = '{1'b1, 5'h08, 8'hFF, 5'h08, 8'h1F};
        vecs[9]  = '{1'b1, 5'h08, 8'h00, 5'h08, 8'h00};
        vecs[10] = '{1'b1, 5'h0A, 8'h55, 5'h0A, 8'h00};
        vecs[11] = '{1'b1, 5'h0D, 8'h12, 5'h0D, 8'h00};
        vecs[12] = '{1'b1, 5'h0F, 8'h3E, 5'h0F, 8'h3E};
        vecs[13] = '{1'b1, 5'h1B, 8'hC7, 5'h1B, 8'hC7};
        vecs[14] = '{1'b1, 5'h0B, 8'h12, 5'h0B, 8'h12};
        vecs[15] = '{1'b1, 5'h0C, 8'h34, 5'h0C, 8'h34};
        vecs[16] = '{1'b0, 5'h00, 8'h00, 5'h0F, 8'h3E};
        vecs[17] = '{1'b1, 5'h0E, 8'h00, 5'h0E, 8'h00};

        rst = 1'b1; cen = 1'b0; cs = 1'b0; wrn = 1'b1; addr = '0; din = '0;
        p_in = 32'hC399_5A3C; icap_in = 1'b1;
        step(); step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_p_out", p_out, 32'h0);
        check("rst_p_ddr", p_ddr, 32'h0);
        check("rst_irq", {29'h0, icf_i, ocf_i, tof_i}, 32'h0);
        check("rst_ocmp", 32'(ocmp), 32'h0);
        peek(5'h08); check("rst_tcsr", 32'(dout), 32'h00);
        peek(5'h0B); check("rst_ocrh", 32'(dout), 32'hFF);
        peek(5'h0C); check("rst_ocrl", 32'(dout), 32'hFF);
        peek(5'h09); check("rst_frch", 32'(dout), 32'h00);
        peek(5'h0F); check("rst_scr", 32'(dout), 32'h00);

        // Register table
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].din);
            peek(vecs[i].chk);
            check($sformatf("vec%0d", i), 32'(dout), 32'(vecs[i].exp));
        end
        check("tbl_p_out", p_out, 32'h3C77_81A5);
        check("tbl_p_ddr", p_ddr, 32'h000F_FFF0);
        check("p2_p_out", p2_out, 32'h0000_81A5);
        check("p2_p_ddr", p2_ddr, 32'h0000_FFF0);
        peek(5'h06); check("p2_rd_p3", 32'(d2_dout), 32'hFF);
        peek(5'h07); check("p2_rd_p4", 32'(d2_dout), 32'hFF);

        // Counter load and read latch
        do_reset();
        wr(5'h09, 8'h00);
        peek(5'h09); check("frc_load", 32'(dout), 32'hFF);
        idle(3);
        rd(5'h09, 8'hFF, "frch_rd");
        idle(5);
        peek(5'h09); check("frc_live", 32'(dout), 32'h00);
        peek(5'h0A); check("latch_peek", 32'(dout), 32'hFB);
        rd(5'h0A, 8'hFB, "latch_rd");

        // Overflow and TOF clear protocol
        do_reset();
        wr(5'h0B, 8'h00);
        wr(5'h08, 8'h04);
        wr(5'h09, 8'h00);
        idle(7);
        check("tof_pre", 32'(tof_i), 32'h0);
        peek(5'h08); check("tcsr_pre", 32'(dout), 32'h04);
        idle(1);
        check("tof_set", 32'(tof_i), 32'h1);
        peek(5'h09); check("frc_wrap", 32'(dout), 32'h00);
        rd(5'h08, 8'h24, "tcsr_tof");
        rd(5'h09, 8'h00, "frch_clr");
        peek(5'h08); check("tof_clr", 32'(dout), 32'h04);
        check("irq_tof_clr", 32'(tof_i), 32'h0);
        wr(5'h09, 8'h00);
        idle(8);
        rd(5'h09, 8'h00, "frch_noarm");
        peek(5'h08); check("tof_noarm", 32'(dout), 32'h24);
        check("irq_tof_noarm", 32'(tof_i), 32'h1);

        // Output compare on the PRESC=4 instance, 64 cen from reset
        do_reset();
        wr(5'h0B, 8'h00);
        wr(5'h0C, 8'h10);
        wr(5'h08, 8'h09);
        idle(60);
        cs = 1'b1; wrn = 1'b0; addr = 5'h0C; din = 8'h00; cen = 1'b0;
        repeat (20) step();
        cs = 1'b0; wrn = 1'b1;
        check("oc_pre_ocmp", 32'(ocmp4), 32'h0);
        check("oc_pre_irq", 32'(ocf4), 32'h0);
        idle(1);
        check("oc_ocmp", 32'(ocmp4), 32'h1);
        check("oc_irq", 32'(ocf4), 32'h1);
        peek(5'h08); check("oc_tcsr", 32'(d4_dout), 32'h49);
        wr(5'h0B, 8'h00);
        peek(5'h08); check("oc_noarm", 32'(d4_dout), 32'h49);
        cs = 1'b1; wrn = 1'b1; addr = 5'h08; cen = 1'b1;
        step();
        cs = 1'b0; cen = 1'b0;
        wr(5'h0C, 8'h10);
        peek(5'h08); check("oc_clr", 32'(d4_dout), 32'h09);
        check("oc_irq_clr", 32'(ocf4), 32'h0);
        check("oc_ocmp_hold", 32'(ocmp4), 32'h1);

        // Input capture, falling edge selected
        do_reset();
        wr(5'h08, 8'h10);
        wr(5'h09, 8'h00);
        idle(4668);
        peek(5'h09); check("ic_frc", 32'(dout), 32'h12);
        icap_in = 1'b0;
        idle(1);
        peek(5'h0D); check("ic_icrh", 32'(dout), 32'h12);
        peek(5'h0E); check("ic_icrl", 32'(dout), 32'h34);
        peek(5'h08); check("ic_tcsr", 32'(dout), 32'hF0);
        check("ic_irq", 32'(icf_i), 32'h1);
        icap_in = 1'b1;
        idle(1);
        peek(5'h0E); check("ic_rise", 32'(dout), 32'h34);
        rd(5'h08, 8'hF0, "ic_arm");
        icap_in = 1'b0;
        rd(5'h0D, 8'h12, "ic_coinc_rd");
        peek(5'h0E); check("ic_coinc_icr", 32'(dout), 32'h37);
        peek(5'h08); check("ic_coinc_icf", 32'(dout & 8'h80), 32'h80);
        rd(5'h0D, 8'h12, "ic_disarm_rd");
        check("ic_disarm", 32'(icf_i), 32'h1);
        cs = 1'b1; wrn = 1'b1; addr = 5'h08; cen = 1'b1;
        step();
        cs = 1'b0; cen = 1'b0;
        rd(5'h0D, 8'h12, "ic_clr_rd");
        peek(5'h08); check("ic_clr", 32'(dout & 8'h80), 32'h00);
        check("ic_irq_clr", 32'(icf_i), 32'h0);

        // Reset in the middle of a count, against a same-cycle write
        do_reset();
        wr(5'h0B, 8'h80);
        wr(5'h0C, 8'h00);
        wr(5'h08, 8'h09);
        wr(5'h02, 8'h5A);
        wr(5'h00, 8'hFF);
        wr(5'h09, 8'h00);
        idle(32776);
        peek(5'h09); check("mid_frc", 32'(dout), 32'h80);
        peek(5'h08); check("mid_tcsr", 32'(dout), 32'h69);
        check("mid_ocmp", 32'(ocmp), 32'h1);
        rst = 1'b1; cs = 1'b1; wrn = 1'b0; addr = 5'h02; din = 8'h55; cen = 1'b1;
        step();
        cs = 1'b0; wrn = 1'b1; cen = 1'b0;
        check("mrst_p_out", p_out, 32'h0);
        check("mrst_p_ddr", p_ddr, 32'h0);
        check("mrst_ocmp", 32'(ocmp), 32'h0);
        check("mrst_irq", {29'h0, icf_i, ocf_i, tof_i}, 32'h0);
        peek(5'h08); check("mrst_tcsr", 32'(dout), 32'h00);
        peek(5'h09); check("mrst_frc", 32'(dout), 32'h00);
        peek(5'h0B); check("mrst_ocr", 32'(dout), 32'hFF);
        peek(5'h02); check("mrst_p1", 32'(dout), 32'h3C);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
